bus_mux_reg: RTL and testbench

- Parametrised, registered successor to the datapath bus multiplexer. Selects one of NUM_SRC source words onto a shared WIDTH-bit bus.
- Source selection is driven by per-source "out" enables. The highest index wins when several enables are asserted.
- Registers the bus, holds the last value when idle, and detects and counts drive conflicts through a small fault state machine.
- Sits between the register file / HI / LO / MDR / RZ outputs and all bus consumers.

---
 rtl/bus_mux_reg.sv | 150 +++++++++++++++
 tb/tb_bus_mux_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// ----------------------------------------------------------------------------
// bus_mux_reg
// Registered, priority-encoded shared-bus multiplexer with conflict detection,
// a saturating conflict counter and a reporting-only fault state machine.
// Optional feature macro: BUS_MUX_PARITY_EN (adds registered bus_par output).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module bus_mux_reg #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 20,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NUM_SRC*WIDTH-1:0]     src_data,
  input  logic [NUM_SRC-1:0]           src_out,
  input  logic                         fault_ack,
  input  logic                         cnt_clr,
  output logic [WIDTH-1:0]             bus_out,
  output logic                         bus_valid,
  output logic [$clog2(NUM_SRC)-1:0]   bus_sel,
  output logic                         conflict,
  output logic                         fault,
`ifdef BUS_MUX_PARITY_EN
  output logic                         bus_par,
`endif
  output logic [CNT_W-1:0]             conflict_cnt
);

  localparam int SEL_W = $clog2(NUM_SRC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  win_data;
  logic [SEL_W-1:0]  win_idx;
  logic              any_en;
  logic              multi_en;

  logic [WIDTH-1:0]  bus_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;
  logic              conflict_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;

  // Priority encoder: ascending scan so the highest asserted index wins.
  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_out[i]) begin
        win_data = src_data[i*WIDTH +: WIDTH];
        win_idx  = SEL_W'(i);
      end
    end
  end

  // Two or more enables: clearing the lowest set bit leaves something behind.
  assign any_en   = |src_out;
  assign multi_en = |(src_out & (src_out - 1'b1));

  // Bus datapath: capture the winner, hold everything but valid when idle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      valid_q    <= any_en;
      conflict_q <= multi_en;
      if (any_en) begin
        bus_q <= win_data;
        sel_q <= win_idx;
      end
    end
  end

  // Conflict counter next state: clear beats increment, saturate at max.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (multi_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fault FSM next state: a fresh conflict always outranks an acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (multi_en)    state_d = S_FAULT;
        else if (any_en) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (multi_en)     state_d = S_FAULT;
        else if (!any_en) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_ack && !multi_en) state_d = any_en ? S_DRIVE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BUS_MUX_PARITY_EN
  logic par_q;

  // Parity tracks bus_q, so it is captured under the same enable.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      par_q <= 1'b0;
    end else if (any_en) begin
      par_q <= ^win_data;
    end
  end

  assign bus_par = par_q;
`else
`endif

  assign bus_out      = bus_q;
  assign bus_sel      = sel_q;
  assign bus_valid    = valid_q;
  assign conflict     = conflict_q;
  assign fault        = (state_q == S_FAULT);
  assign conflict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_mux_reg.sv
// ----------------------------------------------------------------------------
// tb_bus_mux_reg
// Directed, table-driven self-checking bench for bus_mux_reg.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_mux_reg;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 20;

  logic                       clk;
  logic                       clr;
  logic [NUM_SRC*WIDTH-1:0]   src_data;
  logic [NUM_SRC-1:0]         src_out;
  logic                       fault_ack;
  logic                       cnt_clr;

  logic [WIDTH-1:0]  bus_out,  bus_out2;
  logic              bus_valid, bus_valid2;
  logic [4:0]        bus_sel,  bus_sel2;
  logic              conflict, conflict2;
  logic              fault,    fault2;
  logic [7:0]        conflict_cnt;
  logic [1:0]        conflict_cnt2;
`ifdef BUS_MUX_PARITY_EN
  logic              bus_par, bus_par2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bus_mux_reg #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
    .fault_ack(fault_ack), .cnt_clr(cnt_clr),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_sel(bus_sel),
    .conflict(conflict), .fault(fault),
`ifdef BUS_MUX_PARITY_EN
    .bus_par(bus_par),
`endif
    .conflict_cnt(conflict_cnt)
  );

  bus_mux_reg #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .CNT_W(2)) dut_sat (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
    .fault_ack(fault_ack), .cnt_clr(cnt_clr),
    .bus_out(bus_out2), .bus_valid(bus_valid2), .bus_sel(bus_sel2),
    .conflict(conflict2), .fault(fault2),
`ifdef BUS_MUX_PARITY_EN
    .bus_par(bus_par2),
`endif
    .conflict_cnt(conflict_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_SRC-1:0] en;
    int                 ia;
    logic [31:0]        da;
    int                 ib;
    logic [31:0]        db;
    logic               ack;
    logic               cc;
    logic [31:0]        bus;
    int                 sel;
    logic               v;
    logic               c;
    logic               f;
    int                 cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [NUM_SRC-1:0] en, input int ia, input logic [31:0] da,
                            input int ib, input logic [31:0] db, input logic ack, input logic cc);
    src_data = '0;
    src_data[ia*WIDTH +: WIDTH] = da;
    src_data[ib*WIDTH +: WIDTH] = db;
    src_out   = en;
    fault_ack = ack;
    cnt_clr   = cc;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] b, input int s, input logic v,
                         input logic c, input logic f, input int cnt);
    chk({tag, ".bus_out"},   bus_out, b);
    chk({tag, ".bus_sel"},   32'(bus_sel), 32'(s));
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(v));
    chk({tag, ".conflict"},  32'(conflict), 32'(c));
    chk({tag, ".fault"},     32'(fault), 32'(f));
    chk({tag, ".cnt"},       32'(conflict_cnt), 32'(cnt));
  endtask

  initial begin
    //            en          ia  da            ib  db            ack   cc    bus           sel v     c     f     cnt
    vecs[0]  = '{20'h00020,  5, 32'h12345678,  5, 32'h12345678, 1'b0, 1'b0, 32'h12345678,  5, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{20'h00004,  2, 32'hA5A5A5A5,  2, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5,  2, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{20'h00000,  2, 32'h0,         2, 32'h0,        1'b0, 1'b0, 32'hA5A5A5A5,  2, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{20'h00000,  2, 32'h0,         2, 32'h0,        1'b0, 1'b0, 32'hA5A5A5A5,  2, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{20'h00000,  2, 32'h0,         2, 32'h0,        1'b0, 1'b0, 32'hA5A5A5A5,  2, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{20'h80002,  1, 32'h11,       19, 32'h99,       1'b0, 1'b0, 32'h99,       19, 1'b1, 1'b1, 1'b1, 1};
    vecs[6]  = '{20'h00000,  1, 32'h0,         1, 32'h0,        1'b1, 1'b0, 32'h99,       19, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{20'h00001,  0, 32'hCAFEF00D,  0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D,  0, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{20'h00018,  3, 32'h1,         4, 32'h2,        1'b0, 1'b0, 32'h2,         4, 1'b1, 1'b1, 1'b1, 2};
    vecs[9]  = '{20'h00080,  7, 32'h77,        7, 32'h77,       1'b0, 1'b0, 32'h77,        7, 1'b1, 1'b0, 1'b1, 2};
    vecs[10] = '{20'h80001,  0, 32'h5,        19, 32'h6,        1'b1, 1'b0, 32'h6,        19, 1'b1, 1'b1, 1'b1, 3};
    vecs[11] = '{20'h00400, 10, 32'h10,       10, 32'h10,       1'b1, 1'b0, 32'h10,       10, 1'b1, 1'b0, 1'b0, 3};
    vecs[12] = '{20'h00000, 10, 32'h0,        10, 32'h0,        1'b0, 1'b1, 32'h10,       10, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{20'hFFFFF,  0, 32'h1,        19, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 19, 1'b1, 1'b1, 1'b1, 1};
    vecs[14] = '{20'h0000C,  3, 32'h33,        3, 32'h33,       1'b0, 1'b1, 32'h33,        3, 1'b1, 1'b1, 1'b1, 0};

    clr = 1'b1;
    set_inputs('0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    #12;
    chk_all("reset", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    clr = 1'b0;

    // Table-driven main function
    for (int k = 0; k < 15; k++) begin
      set_inputs(vecs[k].en, vecs[k].ia, vecs[k].da, vecs[k].ib, vecs[k].db, vecs[k].ack, vecs[k].cc);
      step();
      chk_all($sformatf("vec%0d", k), vecs[k].bus, vecs[k].sel, vecs[k].v, vecs[k].c, vecs[k].f, vecs[k].cnt);
    end

    // Asynchronous reset mid-cycle during a transfer (FSM currently in FAULT)
    set_inputs(20'h00008, 3, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);
    step();
    chk_all("rst_held", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    clr = 1'b0;
    set_inputs('0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    step();
    chk_all("post_rst_idle", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Saturation: 5 back-to-back conflicts on a 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      set_inputs(20'h00006, 1, 32'h100 + 32'(k), 2, 32'h200 + 32'(k), 1'b0, 1'b0);
      step();
      chk($sformatf("sat%0d.cnt2", k), 32'(conflict_cnt2), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat%0d.cnt8", k), 32'(conflict_cnt), 32'(k));
      chk($sformatf("sat%0d.bus", k), bus_out, 32'h200 + 32'(k));
    end
    set_inputs(20'h00006, 1, 32'h1, 2, 32'h2, 1'b0, 1'b1);
    step();
    chk("sat_clr.cnt2", 32'(conflict_cnt2), 32'd0);
    chk("sat_clr.cnt8", 32'(conflict_cnt), 32'd0);
    chk("sat_clr.conflict", 32'(conflict2), 32'd1);

`ifdef BUS_MUX_PARITY_EN
    set_inputs(20'h00001, 0, 32'h00000007, 0, 32'h00000007, 1'b0, 1'b0);
    step();
    chk("par_7", 32'(bus_par), 32'd1);
    set_inputs(20'h00001, 0, 32'h00000003, 0, 32'h00000003, 1'b0, 1'b0);
    step();
    chk("par_3", 32'(bus_par), 32'd0);
    set_inputs(20'h00001, 0, 32'h00000001, 0, 32'h00000001, 1'b0, 1'b0);
    step();
    chk("par_1", 32'(bus_par), 32'd1);
    set_inputs('0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    step();
    chk("par_hold", 32'(bus_par), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
